// File: rtl/cordiv_array.sv
`default_nettype none
// ============================================================================
// Module   : cordiv_array
// Purpose  : Multi-channel stochastic-computing correlated divider.
//            - Each channel emits a quotient bitstream.
//            - When the divisor bit is 1, the channel passes the dividend bit.
//            - Otherwise it replays a bit taken from a short history of past
//              quotient-generating dividend bits.
//            - The history slot is chosen by a shared 16-bit LFSR.
//            - A windowed ones-counter per channel turns each quotient stream
//              into a binary estimate under a start/done handshake.
// Ports    : clk, rst_n (async, active-low), en (bit-valid strobe),
//            clr (sync clear, highest priority), dividend/divisor [NCH],
//            start (opens a window in IDLE), quotient [NCH] (combinational),
//            busy (window running), done (1-cycle completion pulse),
//            q_cnt [NCH*(CNTW+1)] (latched ones count, channel i at
//            [i*(CNTW+1) +: CNTW+1]).
// Revision : 1.0 - initial release
// ============================================================================
module cordiv_array #(
    parameter int          NCH     = 4,
    parameter int          SRDEPTH = 2,
    parameter int          CNTW    = 8,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      clr,
    input  logic [NCH-1:0]            dividend,
    input  logic [NCH-1:0]            divisor,
    input  logic                      start,
    output logic [NCH-1:0]            quotient,
    output logic                      busy,
    output logic                      done,
    output logic [NCH*(CNTW+1)-1:0]   q_cnt
);

    localparam int              c_selw      = $clog2(SRDEPTH);
    localparam logic [0:0]      c_st_idle   = 1'b0;
    localparam logic [0:0]      c_st_run    = 1'b1;
    localparam logic [CNTW-1:0] c_wcnt_last = '1;
    localparam logic [CNTW-1:0] c_wcnt_one  = CNTW'(1);

    logic [0:0]      r_state;
    logic [CNTW-1:0] r_wcnt;
    logic            r_done;
    logic [15:0]     r_lfsr;
    logic            w_lfsr_fb;
    logic            w_accept;
    logic            w_count;
    logic            w_win_end;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    assign w_accept  = (r_state == c_st_idle) && start;
    assign w_count   = (r_state == c_st_run) && en;
    assign w_win_end = w_count && (r_wcnt == c_wcnt_last);

    assign busy = (r_state == c_st_run);
    assign done = r_done;

    // Window control and shared LFSR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_wcnt  <= '0;
            r_done  <= 1'b0;
            r_lfsr  <= SEED;
        end else if (clr) begin
            r_state <= c_st_idle;
            r_wcnt  <= '0;
            r_done  <= 1'b0;
            r_lfsr  <= SEED;
        end else begin
            r_done <= 1'b0;
            if (en) begin
                r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
            end
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_state <= c_st_run;
                        r_wcnt  <= '0;
                    end
                end
                c_st_run: begin
                    if (en) begin
                        // The counter wraps back to 0 on the final cycle,
                        // which is harmless because IDLE reloads it anyway.
                        r_wcnt <= r_wcnt + c_wcnt_one;
                        if (r_wcnt == c_wcnt_last) begin
                            r_state <= c_st_idle;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [SRDEPTH-1:0] r_sr;
        logic [CNTW:0]      r_acc;
        logic [CNTW:0]      r_qcnt;
        logic [c_selw-1:0]  w_sel;
        logic [CNTW:0]      w_qbit;

        // Each channel taps a different, wrapping slice of the LFSR, so
        // neighbouring channels do not make identical selections.
        for (genvar j = 0; j < c_selw; j++) begin : g_sel
            assign w_sel[j] = r_lfsr[(i * c_selw + j) % 16];
        end

        assign quotient[i] = divisor[i] ? dividend[i] : r_sr[w_sel];
        assign w_qbit      = {{CNTW{1'b0}}, quotient[i]};
        assign q_cnt[i*(CNTW+1) +: CNTW+1] = r_qcnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sr   <= '0;
                r_acc  <= '0;
                r_qcnt <= '0;
            end else if (clr) begin
                r_sr   <= '0;
                r_acc  <= '0;
                r_qcnt <= '0;
            end else begin
                // Only bits that actually produced a quotient (divisor = 1)
                // enter the history.
                if (en && divisor[i]) begin
                    r_sr <= {r_sr[SRDEPTH-2:0], dividend[i]};
                end
                if (w_accept) begin
                    r_acc <= '0;
                end else if (w_count) begin
                    r_acc <= r_acc + w_qbit;
                end
                // The last bit of the window is folded in directly, so the
                // count can reach 2^CNTW without wrapping.
                if (w_win_end) begin
                    r_qcnt <= r_acc + w_qbit;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cordiv_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_cordiv_array
// Purpose  : Self-checking bench for cordiv_array.
//            - Drives randomized and directed bitstreams.
//            - Keeps a behavioural reference model: a history queue per
//              channel, an LFSR value and a window counter.
//            - Compares quotient, busy, done and q_cnt against that model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cordiv_array;

    localparam int          NCH     = 4;
    localparam int          SRDEPTH = 2;
    localparam int          CNTW    = 8;
    localparam logic [15:0] SEED    = 16'hACE1;
    localparam int          SELW    = $clog2(SRDEPTH);
    localparam int          WIN     = 1 << CNTW;
    localparam int          QW      = CNTW + 1;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 en;
    logic                 clr;
    logic                 start;
    logic [NCH-1:0]       dividend;
    logic [NCH-1:0]       divisor;
    logic [NCH-1:0]       quotient;
    logic                 busy;
    logic                 done;
    logic [NCH*QW-1:0]    q_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic [15:0] m_lfsr;
    bit          m_hist [NCH][$];  // index 0 = most recent quotient-generating dividend
    bit          m_busy;
    bit          m_done;
    int          m_cnt;
    int          m_ones [NCH];
    int          m_qcnt [NCH];

    logic [NCH-1:0] obs_q;
    logic [NCH-1:0] exp_q;

    always #5 clk = ~clk;

    cordiv_array #(
        .NCH(NCH), .SRDEPTH(SRDEPTH), .CNTW(CNTW), .SEED(SEED)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .dividend(dividend), .divisor(divisor), .start(start),
        .quotient(quotient), .busy(busy), .done(done), .q_cnt(q_cnt)
    );

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic void model_reset();
        m_lfsr = SEED;
        m_busy = 1'b0;
        m_done = 1'b0;
        m_cnt  = 0;
        for (int i = 0; i < NCH; i++) begin
            m_hist[i].delete();
            m_ones[i] = 0;
            m_qcnt[i] = 0;
        end
    endfunction

    function automatic logic [NCH-1:0] model_quot(input logic [NCH-1:0] dd, input logic [NCH-1:0] dv);
        logic [NCH-1:0] r;
        for (int i = 0; i < NCH; i++) begin
            int sel = 0;
            for (int j = 0; j < SELW; j++) begin
                sel += int'(m_lfsr[(i * SELW + j) % 16]) * (1 << j);
            end
            if (dv[i]) r[i] = dd[i];
            else       r[i] = (sel < m_hist[i].size()) ? m_hist[i][sel] : 1'b0;
        end
        return r;
    endfunction

    function automatic logic [NCH*QW-1:0] exp_qcnt();
        logic [NCH*QW-1:0] v;
        for (int i = 0; i < NCH; i++) v[i*QW +: QW] = QW'(m_qcnt[i]);
        return v;
    endfunction

    function automatic void model_edge(input logic s, input logic e, input logic c,
                                       input logic [NCH-1:0] dd, input logic [NCH-1:0] dv);
        logic [NCH-1:0] q;
        q = model_quot(dd, dv);
        m_done = 1'b0;
        if (c) begin
            model_reset();
            return;
        end
        if (!m_busy) begin
            if (s) begin
                m_busy = 1'b1;
                m_cnt  = 0;
                for (int i = 0; i < NCH; i++) m_ones[i] = 0;
            end
        end else if (e) begin
            for (int i = 0; i < NCH; i++) m_ones[i] += int'(q[i]);
            m_cnt++;
            if (m_cnt == WIN) begin
                for (int i = 0; i < NCH; i++) m_qcnt[i] = m_ones[i];
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end
        if (e) begin
            for (int i = 0; i < NCH; i++) begin
                if (dv[i]) begin
                    m_hist[i].push_front(dd[i]);
                    if (m_hist[i].size() > SRDEPTH) void'(m_hist[i].pop_back());
                end
            end
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    endfunction

    // ------------------------------------------------------------------
    // Stimulus helpers (no checking inside)
    // ------------------------------------------------------------------
    // Drive one cycle: sample quotient at negedge, advance model at posedge.
    task automatic tick(input logic s, input logic e, input logic c,
                        input logic [NCH-1:0] dd, input logic [NCH-1:0] dv);
        start = s; en = e; clr = c; dividend = dd; divisor = dv;
        @(negedge clk);
        obs_q = quotient;
        exp_q = model_quot(dd, dv);
        @(posedge clk);
        model_edge(s, e, c, dd, dv);
        #1;
    endtask

    // Correlated pair from one shared random byte per channel: dd implies dv.
    task automatic rand_pair(output logic [NCH-1:0] dd, output logic [NCH-1:0] dv);
        for (int i = 0; i < NCH; i++) begin
            int r = $urandom_range(0, 255);
            dv[i] = (r < 160);
            dd[i] = (r < 80);
        end
    endtask

    function automatic logic [7:0] bitrev8(input logic [7:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = x[7-i];
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [NCH-1:0] dd, dv;
        rst_n = 1'b0; start = 1'b0; en = 1'b0; clr = 1'b0;
        rand_pair(dd, dv);
        dividend = dd; divisor = dv;
        model_reset();
        #3;
        n_checks++;
        if ({busy, done, q_cnt} !== {1'b0, 1'b0, {(NCH*QW){1'b0}}}) begin
            n_errors++;
            $display("FAIL reset_outputs busy=%b done=%b q_cnt=%h want 0/0/0", busy, done, q_cnt);
        end
        n_checks++;
        if (quotient !== (dd & dv)) begin
            n_errors++;
            $display("FAIL reset_quotient got %b want %b", quotient, dd & dv);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_divisor_ones();
        logic [NCH-1:0] dd;
        tick(1'b1, 1'b1, 1'b0, '0, '1);
        for (int k = 0; k < WIN; k++) begin
            dd = (k % 4 == 0) ? '1 : '0;
            tick(1'b0, 1'b1, 1'b0, dd, '1);
            n_checks++;
            if (obs_q !== exp_q || obs_q !== dd) begin
                n_errors++;
                $display("FAIL div1_quotient k=%0d got %b want %b", k, obs_q, dd);
            end
            n_checks++;
            if ({busy, done, q_cnt} !== {m_busy, m_done, exp_qcnt()}) begin
                n_errors++;
                $display("FAIL div1_state k=%0d got %b/%b/%h want %b/%b/%h",
                         k, busy, done, q_cnt, m_busy, m_done, exp_qcnt());
            end
        end
        for (int i = 0; i < NCH; i++) begin
            n_checks++;
            if (q_cnt[i*QW +: QW] !== QW'(64) || done !== 1'b1) begin
                n_errors++;
                $display("FAIL div1_count ch=%0d got %0d done=%b want 64 done=1",
                         i, q_cnt[i*QW +: QW], done);
            end
        end
        tick(1'b0, 1'b1, 1'b0, '0, '1);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL div1_done_width got done=%b busy=%b want 0/0", done, busy);
        end
    endtask

    task automatic test_hold();
        logic [NCH-1:0] dd;
        tick(1'b0, 1'b0, 1'b1, '0, '0);
        tick(1'b0, 1'b1, 1'b0, '1, '1);
        tick(1'b0, 1'b1, 1'b0, '1, '1);
        for (int k = 0; k < 10; k++) begin
            dd = NCH'($urandom);
            tick(1'b0, 1'b1, 1'b0, dd, '0);
            n_checks++;
            if (obs_q !== exp_q || obs_q !== '1) begin
                n_errors++;
                $display("FAIL hold_quotient k=%0d got %b want %b", k, obs_q, {NCH{1'b1}});
            end
        end
    endtask

    task automatic test_correlated();
        logic [7:0] r;
        logic [NCH-1:0] dd, dv;
        tick(1'b1, 1'b1, 1'b0, '0, '0);
        for (int k = 0; k < WIN; k++) begin
            r  = bitrev8(8'(k));
            dd = (r < 8'd64)  ? '1 : '0;
            dv = (r < 8'd128) ? '1 : '0;
            tick(1'b0, 1'b1, 1'b0, dd, dv);
            n_checks++;
            if (obs_q !== exp_q) begin
                n_errors++;
                $display("FAIL corr_quotient k=%0d got %b want %b", k, obs_q, exp_q);
            end
        end
        n_checks++;
        if ({busy, done, q_cnt} !== {m_busy, m_done, exp_qcnt()}) begin
            n_errors++;
            $display("FAIL corr_state got %b/%b/%h want %b/%b/%h",
                     busy, done, q_cnt, m_busy, m_done, exp_qcnt());
        end
        for (int i = 0; i < NCH; i++) begin
            n_checks++;
            if (int'(q_cnt[i*QW +: QW]) < 112 || int'(q_cnt[i*QW +: QW]) > 144) begin
                n_errors++;
                $display("FAIL corr_range ch=%0d got %0d want 112..144", i, q_cnt[i*QW +: QW]);
            end
        end
    endtask

    task automatic test_en_toggle();
        logic [NCH-1:0] dd, dv;
        logic e;
        int n_en = 0;
        bit finished = 0;
        tick(1'b1, 1'b1, 1'b0, '0, '0);
        for (int k = 0; k < 1500 && !finished; k++) begin
            e = 1'($urandom);
            rand_pair(dd, dv);
            tick(1'b0, e, 1'b0, dd, dv);
            if (e) n_en++;
            n_checks++;
            if (obs_q !== exp_q) begin
                n_errors++;
                $display("FAIL en_quotient k=%0d got %b want %b", k, obs_q, exp_q);
            end
            n_checks++;
            if ({busy, done, q_cnt} !== {m_busy, m_done, exp_qcnt()}) begin
                n_errors++;
                $display("FAIL en_state k=%0d got %b/%b/%h want %b/%b/%h",
                         k, busy, done, q_cnt, m_busy, m_done, exp_qcnt());
            end
            if (done === 1'b1) finished = 1;
        end
        n_checks++;
        if (!finished || n_en != WIN) begin
            n_errors++;
            $display("FAIL en_window finished=%0d en_cycles=%0d want 1/%0d", finished, n_en, WIN);
        end
    endtask

    task automatic test_start_overlap();
        logic [NCH-1:0] dd, dv;
        logic s;
        bit prev_done = 0;
        bit seen = 0;
        tick(1'b1, 1'b1, 1'b0, '0, '0);
        for (int k = 0; k < 600 && !seen; k++) begin
            s = (k == 100) ? 1'b1 : prev_done;
            rand_pair(dd, dv);
            tick(s, 1'b1, 1'b0, dd, dv);
            n_checks++;
            if ({busy, done, q_cnt} !== {m_busy, m_done, exp_qcnt()} || obs_q !== exp_q) begin
                n_errors++;
                $display("FAIL overlap_state k=%0d got %b/%b/%h/%b want %b/%b/%h/%b",
                         k, busy, done, q_cnt, obs_q, m_busy, m_done, exp_qcnt(), exp_q);
            end
            if (s && prev_done) begin
                seen = 1;
                n_checks++;
                if (busy !== 1'b1) begin
                    n_errors++;
                    $display("FAIL overlap_restart got busy=%b want 1", busy);
                end
            end
            prev_done = done;
        end
        n_checks++;
        if (!seen) begin
            n_errors++;
            $display("FAIL overlap_timeout got no done within budget want done");
        end
    endtask

    task automatic test_reset_clr();
        logic [NCH-1:0] dd, dv;
        for (int k = 0; k < 50; k++) begin
            rand_pair(dd, dv);
            tick(1'b0, 1'b1, 1'b0, dd, dv);
        end
        start = 1'b0; en = 1'b0; clr = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #2;
        n_checks++;
        if ({busy, done, q_cnt} !== {1'b0, 1'b0, {(NCH*QW){1'b0}}}) begin
            n_errors++;
            $display("FAIL rst_mid got %b/%b/%h want 0/0/0", busy, done, q_cnt);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        // Full window so q_cnt holds a value, then a partial one cleared by clr.
        for (int w = 0; w < 2; w++) begin
            tick(1'b1, 1'b1, 1'b0, '0, '0);
            for (int k = 0; k < ((w == 0) ? WIN : 50); k++) begin
                rand_pair(dd, dv);
                tick(1'b0, 1'b1, 1'b0, dd, dv);
            end
        end
        n_checks++;
        if (busy !== 1'b1 || q_cnt !== exp_qcnt()) begin
            n_errors++;
            $display("FAIL clr_pre got busy=%b q_cnt=%h want 1/%h", busy, q_cnt, exp_qcnt());
        end
        rand_pair(dd, dv);
        tick(1'b0, 1'b1, 1'b1, dd, dv);
        n_checks++;
        if ({busy, done, q_cnt} !== {1'b0, 1'b0, {(NCH*QW){1'b0}}}) begin
            n_errors++;
            $display("FAIL clr_mid got %b/%b/%h want 0/0/0", busy, done, q_cnt);
        end
        rand_pair(dd, dv);
        tick(1'b1, 1'b1, 1'b1, dd, dv);
        n_checks++;
        if ({busy, done, q_cnt} !== {1'b0, 1'b0, {(NCH*QW){1'b0}}}) begin
            n_errors++;
            $display("FAIL clr_start got %b/%b/%h want 0/0/0", busy, done, q_cnt);
        end
        // Quotient after clear depends on a restarted LFSR and empty history.
        for (int k = 0; k < 20; k++) begin
            rand_pair(dd, dv);
            tick(1'b0, 1'b1, 1'b0, dd, dv);
            n_checks++;
            if (obs_q !== exp_q || {busy, done} !== 2'b00) begin
                n_errors++;
                $display("FAIL clr_after k=%0d got %b/%b%b want %b/00", k, obs_q, busy, done, exp_q);
            end
        end
    endtask

    initial begin
        test_reset();
        test_divisor_ones();
        test_hold();
        test_correlated();
        test_en_toggle();
        test_start_overlap();
        test_reset_clr();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
